// File: rtl/neighbor_table_update.sv
// Neighbor table updater: searches the stored neighbor IDs for a packet's source and
// updates the entry or appends a new one. Define NEIGHBOR_ENERGY_EN to also store energy.
module neighbor_table_update (
   input  logic        i_clock,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic        i_start,
   input  logic [15:0] i_node_id,
   input  logic [15:0] i_pkt_src_id,
   input  logic [15:0] i_pkt_cluster_id,
   input  logic [15:0] i_pkt_q_value,
   input  logic [15:0] i_pkt_energy,
   input  logic [15:0] i_data_in,
   output logic [10:0] o_address,
   output logic [15:0] o_data_out,
   output logic        o_wr_en,
   output logic        o_done,
   output logic        o_found,
   output logic        o_full,
   output logic [5:0]  o_index
);

   localparam logic [10:0] AddrId    = 11'h032;
   localparam logic [10:0] AddrCid   = 11'h0B2;
   localparam logic [10:0] AddrQ     = 11'h132;
   localparam logic [10:0] AddrE     = 11'h1B2;
   localparam logic [10:0] AddrCount = 11'h274;
   localparam logic [15:0] MaxCount  = 16'd64;

   typedef enum logic [3:0] {
      StIdle, StStart, StCount, StSearch, StCmp, StWrId, StWrCid, StWrQ, StWrE, StWrCount, StDone
   } state_t;

   state_t      r_state, w_state_d;
   logic [15:0] r_src, r_cid, r_q;
   logic [15:0] r_count, w_count_d;
   logic [15:0] r_i, w_i_d;
   logic        r_found, w_found_d;
   logic        r_full, w_full_d;
   logic [5:0]  r_index, w_index_d;
   logic [10:0] r_address, w_address_d;
   logic [15:0] r_data_out, w_data_out_d;
   logic        r_wr_en, w_wr_en_d;
   logic        r_done, w_done_d;
   logic [15:0] w_count_in;
   logic [10:0] w_slot_off, w_scan_off;
   logic        w_latch;

`ifdef NEIGHBOR_ENERGY_EN
   logic [15:0] r_energy;
`else
   logic [15:0] w_unused_energy;
   assign w_unused_energy = i_pkt_energy;
`endif

   // Stored counts beyond the table capacity are treated as a full table.
   assign w_count_in = (i_data_in > MaxCount) ? MaxCount : i_data_in;
   assign w_latch    = (r_state == StStart) && i_start;

   always_comb begin
      w_state_d = r_state;
      w_count_d = r_count;
      w_i_d     = r_i;
      w_found_d = r_found;
      w_full_d  = r_full;
      w_index_d = r_index;
      case (r_state)
         StIdle: begin
            w_count_d = '0;
            w_i_d     = '0;
            w_found_d = 1'b0;
            w_full_d  = 1'b0;
            w_index_d = '0;
            w_state_d = StStart;
         end
         StStart: begin
            if (i_start) w_state_d = StCount;
         end
         StCount: begin
            w_count_d = w_count_in;
            w_i_d     = '0;
            if (r_src == i_node_id) begin
               w_state_d = StDone;
            end else if (w_count_in == 16'd0) begin
               w_index_d = '0;
               w_state_d = StWrId;
            end else begin
               w_state_d = StSearch;
            end
         end
         StSearch: w_state_d = StCmp;
         StCmp: begin
            if (i_data_in == r_src) begin
               w_found_d = 1'b1;
               w_index_d = r_i[5:0];
               w_state_d = StWrCid;
            end else begin
               w_i_d = r_i + 16'd1;
               if (w_i_d == r_count) begin
                  if (r_count == MaxCount) begin
                     w_full_d  = 1'b1;
                     w_state_d = StDone;
                  end else begin
                     w_index_d = r_count[5:0];
                     w_state_d = StWrId;
                  end
               end else begin
                  w_state_d = StSearch;
               end
            end
         end
         StWrId:  w_state_d = StWrCid;
         StWrCid: w_state_d = StWrQ;
`ifdef NEIGHBOR_ENERGY_EN
         StWrQ:   w_state_d = StWrE;
         StWrE:   w_state_d = r_found ? StDone : StWrCount;
`else
         StWrQ:   w_state_d = r_found ? StDone : StWrCount;
`endif
         StWrCount: w_state_d = StDone;
         StDone:    w_state_d = StDone;
         default:   w_state_d = StIdle;
      endcase
      if (!i_en) w_state_d = StIdle;
   end

   // Bus outputs are registered and describe the access made in the state being entered.
   assign w_slot_off = {4'd0, w_index_d, 1'b0};
   assign w_scan_off = {w_i_d[9:0], 1'b0};

   always_comb begin
      w_address_d  = r_address;
      w_data_out_d = '0;
      w_wr_en_d    = 1'b0;
      w_done_d     = (w_state_d == StDone);
      case (w_state_d)
         StCount:  w_address_d = AddrCount;
         StSearch: w_address_d = AddrId + w_scan_off;
         StWrId: begin
            w_address_d  = AddrId + w_slot_off;
            w_data_out_d = r_src;
            w_wr_en_d    = 1'b1;
         end
         StWrCid: begin
            w_address_d  = AddrCid + w_slot_off;
            w_data_out_d = r_cid;
            w_wr_en_d    = 1'b1;
         end
         StWrQ: begin
            w_address_d  = AddrQ + w_slot_off;
            w_data_out_d = r_q;
            w_wr_en_d    = 1'b1;
         end
`ifdef NEIGHBOR_ENERGY_EN
         StWrE: begin
            w_address_d  = AddrE + w_slot_off;
            w_data_out_d = r_energy;
            w_wr_en_d    = 1'b1;
         end
`endif
         StWrCount: begin
            w_address_d  = AddrCount;
            w_data_out_d = r_count + 16'd1;
            w_wr_en_d    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_rst) begin
         r_state    <= StIdle;
         r_src      <= '0;
         r_cid      <= '0;
         r_q        <= '0;
         r_count    <= '0;
         r_i        <= '0;
         r_found    <= 1'b0;
         r_full     <= 1'b0;
         r_index    <= '0;
         r_address  <= AddrCount;
         r_data_out <= '0;
         r_wr_en    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_count    <= w_count_d;
         r_i        <= w_i_d;
         r_found    <= w_found_d;
         r_full     <= w_full_d;
         r_index    <= w_index_d;
         r_address  <= w_address_d;
         r_data_out <= w_data_out_d;
         r_wr_en    <= w_wr_en_d;
         r_done     <= w_done_d;
         if (w_latch) begin
            r_src <= i_pkt_src_id;
            r_cid <= i_pkt_cluster_id;
            r_q   <= i_pkt_q_value;
         end
      end
   end

`ifdef NEIGHBOR_ENERGY_EN
   always_ff @(posedge i_clock) begin
      if (i_rst)        r_energy <= '0;
      else if (w_latch) r_energy <= i_pkt_energy;
   end
`endif

   assign o_address  = r_address;
   assign o_data_out = r_data_out;
   assign o_wr_en    = r_wr_en;
   assign o_done     = r_done;
   assign o_found    = r_found;
   assign o_full     = r_full;
   assign o_index    = r_index;

endmodule
